mips_mc: RTL

MIPS_MC -- requirements
Module: mips_mc

---
 rtl/mips_mc.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/mips_mc.sv
// mips_mc: multi-cycle MIPS subset core (FETCH/DECODE/EXEC/MEM/WB), one
// instruction in flight, separate instruction and data RAM handshakes.
//
// Optional feature: define MIPS_MC_BNE_EN to support bne (opcode 0x05);
// without it, 0x05 decodes as illegal.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   instr           instruction word, valid when instr_ready=1
//   instr_ready     instruction RAM ready
//   ReadData        data RAM read word
//   data_ready      data RAM access completes this cycle
//   PC              current fetch address (ADDR_W bits)
//   inst_ram_ena    instruction fetch request
//   AluOut          data address (registered ALU result)
//   WriteData       store data (registered rt)
//   data_ram_ena    data access request
//   data_ram_wea    data write strobe (only with data_ram_ena)
//   illegal         one-cycle pulse on unsupported opcode/funct
module mips_mc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr,
  input  logic              instr_ready,
  input  logic [31:0]       ReadData,
  input  logic              data_ready,
  output logic [ADDR_W-1:0] PC,
  output logic              inst_ram_ena,
  output logic [ADDR_W-1:0] AluOut,
  output logic [31:0]       WriteData,
  output logic              data_ram_ena,
  output logic              data_ram_wea,
  output logic              illegal
);

`ifdef MIPS_MC_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       ir_q, a_q, b_q, imm_q, alu_q, mdr_q;
  logic [31:0]       rf_q [32];

  logic inst_ram_ena_q, inst_ram_ena_d;
  logic data_ram_ena_q, data_ram_ena_d;
  logic data_ram_wea_q, data_ram_wea_d;
  logic illegal_q, illegal_d;

  // Instruction decode from the latched IR
  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;
  logic       is_r, is_j, is_beq, is_bne, is_addi, is_lw, is_sw, valid;

  always_comb begin
    op      = ir_q[31:26];
    funct   = ir_q[5:0];
    rs      = ir_q[25:21];
    rt      = ir_q[20:16];
    rd      = ir_q[15:11];
    is_r    = (op == OP_R) &&
              ((funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
               (funct == FN_OR)  || (funct == FN_SLT));
    is_j    = (op == OP_J);
    is_beq  = (op == OP_BEQ);
    is_bne  = BNE_EN && (op == OP_BNE);
    is_addi = (op == OP_ADDI);
    is_lw   = (op == OP_LW);
    is_sw   = (op == OP_SW);
    valid   = is_r || is_j || is_beq || is_bne || is_addi || is_lw || is_sw;
  end

  // ALU for R-type and addi; add/sub wrap, slt is signed
  logic [31:0] alu_res;
  always_comb begin
    alu_res = a_q + imm_q;
    if (is_r) begin
      case (funct)
        FN_ADD:  alu_res = a_q + b_q;
        FN_SUB:  alu_res = a_q - b_q;
        FN_AND:  alu_res = a_q & b_q;
        FN_OR:   alu_res = a_q | b_q;
        FN_SLT:  alu_res = ($signed(a_q) < $signed(b_q)) ? 32'd1 : 32'd0;
        default: alu_res = a_q + b_q;
      endcase
    end
  end

  // Branch/jump targets; PC already points at the next instruction
  logic [31:0] pc_ext, jump_tgt, br_off;
  always_comb begin
    pc_ext   = 32'(pc_q);
    jump_tgt = (pc_ext & 32'hF000_0000) | {4'b0000, ir_q[25:0], 2'b00};
    br_off   = imm_q << 2;
  end

  // Register write-back port
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  always_comb begin
    wb_addr = is_r ? rd : rt;
    wb_data = is_lw ? mdr_q : alu_q;
  end

  // State register plus registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_FETCH;
      inst_ram_ena_q <= 1'b1;
      data_ram_ena_q <= 1'b0;
      data_ram_wea_q <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      inst_ram_ena_q <= inst_ram_ena_d;
      data_ram_ena_q <= data_ram_ena_d;
      data_ram_wea_q <= data_ram_wea_d;
      illegal_q      <= illegal_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (instr_ready) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (is_r || is_addi)     state_d = S_WB;
        else if (is_lw || is_sw) state_d = S_MEM;
        else                     state_d = S_FETCH;
      end
      S_MEM:    if (data_ready) state_d = is_sw ? S_FETCH : S_WB;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Output logic: values for the state about to be entered, so the
  // registered strobes line up with the state they belong to
  always_comb begin
    inst_ram_ena_d = 1'b0;
    data_ram_ena_d = 1'b0;
    data_ram_wea_d = 1'b0;
    illegal_d      = 1'b0;
    case (state_d)
      S_FETCH: inst_ram_ena_d = 1'b1;
      S_MEM: begin
        data_ram_ena_d = 1'b1;
        data_ram_wea_d = is_sw;
      end
      S_EXEC:  illegal_d = !valid;
      default: ;
    endcase
  end

  // Datapath and register file
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= ADDR_W'(RESET_PC);
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      imm_q <= '0;
      alu_q <= '0;
      mdr_q <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (instr_ready) begin
            ir_q <= instr;
            pc_q <= pc_q + ADDR_W'(4);
          end
        end
        S_DECODE: begin
          a_q   <= rf_q[rs];
          b_q   <= rf_q[rt];
          imm_q <= {{16{ir_q[15]}}, ir_q[15:0]};
        end
        S_EXEC: begin
          if (is_r || is_addi)                   alu_q <= alu_res;
          else if (is_lw || is_sw)               alu_q <= a_q + imm_q;
          else if (is_beq && (a_q == b_q))       pc_q  <= pc_q + ADDR_W'(br_off);
          else if (is_bne && (a_q != b_q))       pc_q  <= pc_q + ADDR_W'(br_off);
          else if (is_j)                         pc_q  <= ADDR_W'(jump_tgt);
        end
        S_MEM: begin
          if (data_ready && is_lw) mdr_q <= ReadData;
        end
        S_WB: begin
          if (wb_addr != 5'd0) rf_q[wb_addr] <= wb_data;
        end
        default: ;
      endcase
    end
  end

  assign PC           = pc_q;
  assign AluOut       = ADDR_W'(alu_q);
  assign WriteData    = b_q;
  assign inst_ram_ena = inst_ram_ena_q;
  assign data_ram_ena = data_ram_ena_q;
  assign data_ram_wea = data_ram_wea_q;
  assign illegal      = illegal_q;

endmodule
